// File: rtl/apu_voice_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : apu_voice_engine_if
// Purpose  : Sample stream between the voice engine and the I2S controller.
//            The engine presents a mixed sample with a valid flag and a sticky
//            overrun flag. The sink answers with ready.
// Signals  : sample_out   [OUT_W] mixed unsigned sample
//            sample_valid         sample_out holds an unconsumed sample
//            sample_ready         sink accepts sample_out this cycle
//            overrun              sticky: a sample was overwritten unconsumed
// Modports : master (engine side), slave (sink side)
// Revision : 1.0 - initial release
// ============================================================================
interface apu_voice_engine_if #(
  parameter int OUT_W = 16
);
  logic [OUT_W-1:0] sample_out;
  logic             sample_valid;
  logic             sample_ready;
  logic             overrun;

  modport master (
    output sample_out,
    output sample_valid,
    output overrun,
    input  sample_ready
  );

  modport slave (
    input  sample_out,
    input  sample_valid,
    input  overrun,
    output sample_ready
  );
endinterface
`default_nettype wire

// File: rtl/apu_voice_engine.sv
`default_nettype none
// ============================================================================
// Module   : apu_voice_engine
// Purpose  : N-channel voice core. Each channel has a phase counter, a pulse
//            generator with selectable duty and a decay envelope. A saturating
//            mixer emits one unsigned sample every SAMPLE_DIV clocks over a
//            valid/ready stream with sticky overrun reporting.
// Ports    : clk, reset_n (async, active low)
//            period_flat [NUM_CH*PER_W] channel periods (0 = silent)
//            duty_flat   [NUM_CH*2]     duty: 0=50%, 1=25%, 2=12.5%, 3=75%
//            key_on      [NUM_CH]       level gate per channel
//            decay_en    [NUM_CH]       envelope decays while keyed
//            smp         master modport of apu_voice_engine_if
//            ch_active   [NUM_CH]       envelope level of channel is nonzero
// Config   : APU_NOISE_CH_EN - when defined, channel NUM_CH-1 is a noise
//            channel driven by a 15-bit LFSR that steps once per phase wrap.
// Revision : 1.0 - initial release
// ============================================================================
module apu_voice_engine #(
  parameter int NUM_CH     = 4,
  parameter int PER_W      = 32,
  parameter int ENV_W      = 4,
  parameter int OUT_W      = 16,
  parameter int MIX_SHIFT  = 10,
  parameter int SAMPLE_DIV = 256,
  parameter int DECAY_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH*PER_W-1:0] period_flat,
  input  logic [NUM_CH*2-1:0]     duty_flat,
  input  logic [NUM_CH-1:0]       key_on,
  input  logic [NUM_CH-1:0]       decay_en,
  apu_voice_engine_if.master      smp,
  output logic [NUM_CH-1:0]       ch_active
);

  localparam int SUM_W  = ENV_W + $clog2(NUM_CH);
  localparam int MIX_W  = SUM_W + MIX_SHIFT;
  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int DCNT_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [PER_W-1:0]  period   [NUM_CH];
  logic [1:0]        duty     [NUM_CH];
  logic [PER_W-1:0]  cnt_q    [NUM_CH];
  logic [PER_W-1:0]  cnt_d    [NUM_CH];
  logic [ENV_W-1:0]  level_q  [NUM_CH];
  logic [ENV_W-1:0]  level_d  [NUM_CH];
  logic [DCNT_W-1:0] dcnt_q   [NUM_CH];
  logic [DCNT_W-1:0] dcnt_d   [NUM_CH];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] tone_pulse;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] key_prev_q;
  logic [NUM_CH-1:0] ch_active_q;
  logic [NUM_CH-1:0] ch_active_d;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [TICK_W-1:0] tick_cnt_d;
  logic              tick;
  logic [SUM_W-1:0]  sum;
  logic [MIX_W-1:0]  mix_wide;
  logic [OUT_W-1:0]  mix_sat;
  logic [OUT_W-1:0]  sample_q;
  logic [OUT_W-1:0]  sample_d;
  logic              valid_q;
  logic              valid_d;
  logic              overrun_q;
  logic              overrun_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign period[c] = period_flat[c*PER_W +: PER_W];
    assign duty[c]   = duty_flat[2*c +: 2];
  end

  // Phase counters. Comparing with >= (not ==) lets a counter that is already
  // past a freshly lowered period wrap on the very next clock.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = '0;
      wrap[c]  = 1'b0;
      if (period[c] != '0) begin
        if (cnt_q[c] >= period[c] - PER_W'(1)) begin
          wrap[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + PER_W'(1);
        end
      end
    end
  end

  // Pulse generators. A zero threshold (very short periods) forces the output
  // low for every duty, including the inverted 75% setting.
  always_comb begin
    logic [PER_W-1:0] thr;
    thr        = '0;
    tone_pulse = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (duty[c])
        2'd0:    thr = period[c] >> 1;
        2'd1:    thr = period[c] >> 2;
        2'd2:    thr = period[c] >> 3;
        default: thr = period[c] >> 2;
      endcase
      if (thr != '0) begin
        tone_pulse[c] = (duty[c] == 2'd3) ? (cnt_q[c] >= thr) : (cnt_q[c] < thr);
      end
    end
  end

`ifdef APU_NOISE_CH_EN
  logic [14:0] lfsr_q;
  logic [14:0] lfsr_d;

  // The LFSR only moves on a phase wrap, so a zero period freezes it.
  always_comb begin
    lfsr_d = lfsr_q;
    if (wrap[NUM_CH-1]) begin
      lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 15'h0001;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign pulse = {lfsr_q[0] & (period[NUM_CH-1] != '0), tone_pulse[NUM_CH-2:0]};
`else
  assign pulse = tone_pulse;
`endif

  // Sample tick divider.
  assign tick       = (tick_cnt_q == TICK_W'(SAMPLE_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  // Mixer: sum of gated envelope levels, shifted, then clipped to OUT_W.
  always_comb begin
    sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pulse[c]) begin
        sum = sum + SUM_W'(level_q[c]);
      end
    end
  end

  assign mix_wide = MIX_W'(sum) << MIX_SHIFT;

  if (MIX_W > OUT_W) begin : g_sat
    assign mix_sat = (|mix_wide[MIX_W-1:OUT_W]) ? '1 : mix_wide[OUT_W-1:0];
  end else begin : g_nosat
    assign mix_sat = OUT_W'(mix_wide);
  end

  // Envelopes. Key release clears immediately; a key rise reloads full scale;
  // decay counts sample ticks and steps the level down every DECAY_DIV ticks.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      level_d[c] = level_q[c];
      dcnt_d[c]  = dcnt_q[c];
      if (!key_on[c]) begin
        level_d[c] = '0;
        dcnt_d[c]  = '0;
      end else if (!key_prev_q[c]) begin
        level_d[c] = '1;
        dcnt_d[c]  = '0;
      end else if (decay_en[c] && tick) begin
        if (dcnt_q[c] == DCNT_W'(DECAY_DIV - 1)) begin
          dcnt_d[c] = '0;
          if (level_q[c] != '0) begin
            level_d[c] = level_q[c] - ENV_W'(1);
          end
        end else begin
          dcnt_d[c] = dcnt_q[c] + DCNT_W'(1);
        end
      end
      ch_active_d[c] = (level_d[c] != '0);
    end
  end

  // Output handshake. A tick always loads a new sample; if the previous one
  // was still waiting and not being taken, it is lost and overrun latches.
  always_comb begin
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (tick) begin
      sample_d = mix_sat;
      valid_d  = 1'b1;
      if (valid_q && !smp.sample_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && smp.sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]   <= '0;
        level_q[c] <= '0;
        dcnt_q[c]  <= '0;
      end
      key_prev_q  <= '0;
      ch_active_q <= '0;
      tick_cnt_q  <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]   <= cnt_d[c];
        level_q[c] <= level_d[c];
        dcnt_q[c]  <= dcnt_d[c];
      end
      key_prev_q  <= key_on;
      ch_active_q <= ch_active_d;
      tick_cnt_q  <= tick_cnt_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign smp.sample_out   = sample_q;
  assign smp.sample_valid = valid_q;
  assign smp.overrun      = overrun_q;
  assign ch_active        = ch_active_q;

endmodule
`default_nettype wire
